// File: rtl/hpdcache_sram_ecc_pkg.sv
// Shared types and helpers for the SECDED-protected 1RW SRAM wrapper:
// FSM states, mask classification and Hsiao code geometry.
package hpdcache_sram_ecc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MASK_NONE    = 2'd0,
    MASK_FULL    = 2'd1,
    MASK_PARTIAL = 2'd2
  } mask_class_e;

  // A word mask is "none" (all 0s), "full" (all 1s) or "partial" (anything else).
  function automatic mask_class_e mask_class(input logic all_ones, input logic any_one);
    mask_class_e cls;
    if (!any_one) begin
      cls = MASK_NONE;
    end else if (all_ones) begin
      cls = MASK_FULL;
    end else begin
      cls = MASK_PARTIAL;
    end
    return cls;
  endfunction

  // Data widths for which a SECDED code is provided.
  function automatic bit secded_width_valid(input int d);
    return (d == 8) || (d == 16) || (d == 32) || (d == 64);
  endfunction

  // Odd-weight (>= 3) column vectors available with k check bits.
  function automatic int odd_cols(input int k);
    int n;
    n = 0;
    for (int v = 1; v < (1 << k); v++) begin
      if (($countones(v) >= 3) && (($countones(v) % 2) == 1)) begin
        n++;
      end
    end
    return n;
  endfunction

  // Smallest number of check bits whose Hsiao columns cover d data bits.
  function automatic int synd_width(input int d);
    int res;
    res = 0;
    for (int k = 4; k <= 9; k++) begin
      if ((res == 0) && (odd_cols(k) >= d)) begin
        res = k;
      end
    end
    return res;
  endfunction

  // Stored codeword width: data bits plus check bits.
  function automatic int word_width(input int d);
    return d + synd_width(d);
  endfunction

  // H-matrix column for data bit idx: the idx-th odd-weight (>= 3) value.
  function automatic int hsiao_col(input int idx, input int k);
    int n;
    int res;
    n   = 0;
    res = 0;
    for (int v = 1; v < (1 << k); v++) begin
      if (($countones(v) >= 3) && (($countones(v) % 2) == 1)) begin
        if (n == idx) begin
          res = v;
        end
        n++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hpdcache_sram_ecc_merge.sv
// One ECC word: Hsiao SECDED decode of the stored codeword, bit-masked merge
// of new data over the corrected data, re-encode, and data-bit error inject.
module hpdcache_sram_ecc_merge
  import hpdcache_sram_ecc_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic [word_width(DATA_SIZE)-1:0] codeword,
  input  logic [DATA_SIZE-1:0]             wdata,
  input  logic [DATA_SIZE-1:0]             wmask,
  input  logic [DATA_SIZE-1:0]             inj_msk,
  output logic [DATA_SIZE-1:0]             rdata,
  output logic                             err_cor,
  output logic                             err_unc,
  output logic [word_width(DATA_SIZE)-1:0] enc_word
);

  localparam int unsigned SW = synd_width(DATA_SIZE);

  logic [DATA_SIZE-1:0][SW-1:0] col_mat;
  logic [SW-1:0][DATA_SIZE-1:0] row_mat;
  logic [DATA_SIZE-1:0]         stored_data;
  logic [SW-1:0]                stored_chk;
  logic [SW-1:0]                synd;
  logic [DATA_SIZE-1:0]         flip;
  logic [DATA_SIZE-1:0]         merged;
  logic [SW-1:0]                enc_chk;

  assign stored_data = codeword[DATA_SIZE-1:0];
  assign stored_chk  = codeword[DATA_SIZE+SW-1:DATA_SIZE];

  // Constant H matrix, plus its transpose for the parity trees.
  for (genvar gi = 0; gi < DATA_SIZE; gi++) begin : g_col
    localparam int COL = hsiao_col(gi, SW);
    assign col_mat[gi] = SW'(COL);
    for (genvar gj = 0; gj < SW; gj++) begin : g_row
      assign row_mat[gj][gi] = col_mat[gi][gj];
    end
    assign flip[gi] = (synd == col_mat[gi]);
  end

  for (genvar gj = 0; gj < SW; gj++) begin : g_par
    assign synd[gj]    = (^(stored_data & row_mat[gj])) ^ stored_chk[gj];
    assign enc_chk[gj] = ^(merged & row_mat[gj]);
  end

  // Odd syndrome matching a data column or a single check bit is correctable;
  // any other nonzero syndrome is a multi-bit error.
  always_comb begin
    err_cor = 1'b0;
    err_unc = 1'b0;
    if (synd != '0) begin
      if ((^synd) && ((|flip) || $onehot(synd))) begin
        err_cor = 1'b1;
      end else begin
        err_unc = 1'b1;
      end
    end
  end

  assign rdata    = stored_data ^ flip;
  assign merged   = (rdata & ~wmask) | (wdata & wmask);
  assign enc_word = {enc_chk, merged ^ inj_msk};

endmodule

// File: rtl/hpdcache_sram_wmask_1rw.sv
// Single-port SRAM with per-bit write mask and registered read.
module hpdcache_sram_wmask_1rw #(
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned DATA_SIZE = 39,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE,
  parameter int unsigned NDATA     = 2
) (
  input  logic                         clk,
  input  logic                         cs,
  input  logic                         we,
  input  logic [ADDR_SIZE-1:0]         addr,
  input  logic [NDATA*DATA_SIZE-1:0]   wdata,
  input  logic [NDATA*DATA_SIZE-1:0]   wmask,
  output logic [NDATA*DATA_SIZE-1:0]   rdata
);

  logic [NDATA*DATA_SIZE-1:0] mem [DEPTH];

  // Bit-masked write, or read into the output register.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/hpdcache_sram_wmask_ecc_rmw_1rw.sv
// 1RW SRAM wrapper with per-word SECDED, bit-masked writes via
// read-modify-write, correctable-error write-back and error statistics.
module hpdcache_sram_wmask_ecc_rmw_1rw
  import hpdcache_sram_ecc_pkg::*;
#(
  parameter int unsigned ADDR_SIZE     = 6,
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned DEPTH         = 2**ADDR_SIZE,
  parameter int unsigned NDATA         = 2,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned COR_WRITEBACK = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [ADDR_SIZE-1:0]         req_addr_i,
  input  logic [NDATA*DATA_SIZE-1:0]   req_wdata_i,
  input  logic [NDATA*DATA_SIZE-1:0]   req_wmask_i,
  output logic                         rvalid_o,
  output logic [NDATA*DATA_SIZE-1:0]   rdata_o,
  output logic [NDATA-1:0]             err_cor_o,
  output logic [NDATA-1:0]             err_unc_o,
  input  logic                         err_inj_i,
  input  logic [NDATA*DATA_SIZE-1:0]   err_inj_msk_i,
  input  logic                         cnt_clr_i,
  output logic [CNT_WIDTH-1:0]         cor_cnt_o,
  output logic [CNT_WIDTH-1:0]         unc_cnt_o,
  output logic [ADDR_SIZE-1:0]         err_addr_o,
  output logic                         err_addr_valid_o
);

  localparam int unsigned WW = word_width(DATA_SIZE);

  if (!secded_width_valid(DATA_SIZE)) begin : g_bad_width
    $fatal(1, "DATA_SIZE %0d has no SECDED code", DATA_SIZE);
  end

  state_e                   state_reg;
  logic                     rvalid_reg;
  logic [ADDR_SIZE-1:0]     rd_addr_reg;
  logic [ADDR_SIZE-1:0]     rmw_addr_reg;
  logic [NDATA*DATA_SIZE-1:0] rmw_wdata_reg;
  logic [NDATA*DATA_SIZE-1:0] rmw_wmask_reg;
  logic [NDATA*DATA_SIZE-1:0] rmw_inj_reg;
  logic [CNT_WIDTH-1:0]     cor_cnt_reg;
  logic [CNT_WIDTH-1:0]     unc_cnt_reg;
  logic [ADDR_SIZE-1:0]     err_addr_reg;
  logic                     err_addr_valid_reg;

  logic                     sram_cs;
  logic                     sram_we;
  logic [ADDR_SIZE-1:0]     sram_addr;
  logic [NDATA*WW-1:0]      sram_wdata;
  logic [NDATA*WW-1:0]      sram_wmask;
  logic [NDATA*WW-1:0]      sram_rdata;

  logic [NDATA-1:0]         word_all1;
  logic [NDATA-1:0]         word_partial;
  logic [NDATA-1:0]         w_cor;
  logic [NDATA-1:0]         w_unc;
  logic [NDATA-1:0][DATA_SIZE-1:0] m_wdata;
  logic [NDATA-1:0][DATA_SIZE-1:0] m_wmask;
  logic [NDATA-1:0][DATA_SIZE-1:0] m_inj;

  logic                     rmw_active;
  logic                     wb_active;
  logic                     accept;
  logic                     any_partial;
  logic                     ev_valid;
  logic                     ev_cor;
  logic                     ev_unc;
  logic [ADDR_SIZE-1:0]     ev_addr;

  assign rmw_active  = (state_reg == ST_RMW);
  // A clean read of a row with only correctable errors steals the next port cycle.
  assign wb_active   = (COR_WRITEBACK != 0) && rvalid_reg && (|w_cor) && !(|w_unc);
  assign req_ready_o = (state_reg == ST_IDLE) && !wb_active;
  assign accept      = req_valid_i && req_ready_o;
  assign any_partial = |word_partial;

  // Per-word mask classification and the shared decode/merge/encode datapath.
  for (genvar gi = 0; gi < NDATA; gi++) begin : g_word
    mask_class_e cls;
    assign cls = mask_class(&req_wmask_i[gi*DATA_SIZE +: DATA_SIZE],
                            |req_wmask_i[gi*DATA_SIZE +: DATA_SIZE]);
    assign word_all1[gi]    = (cls == MASK_FULL);
    assign word_partial[gi] = (cls == MASK_PARTIAL);

    // RMW merges latched request data; write-back re-encodes corrected data;
    // otherwise a direct write encodes the request data as-is.
    assign m_wdata[gi] = rmw_active ? rmw_wdata_reg[gi*DATA_SIZE +: DATA_SIZE] :
                         wb_active  ? '0 : req_wdata_i[gi*DATA_SIZE +: DATA_SIZE];
    assign m_wmask[gi] = rmw_active ? rmw_wmask_reg[gi*DATA_SIZE +: DATA_SIZE] :
                         wb_active  ? '0 : '1;
    assign m_inj[gi]   = rmw_active ? rmw_inj_reg[gi*DATA_SIZE +: DATA_SIZE] :
                         (wb_active || !err_inj_i) ? '0 :
                         err_inj_msk_i[gi*DATA_SIZE +: DATA_SIZE];

    hpdcache_sram_ecc_merge #(
      .DATA_SIZE (DATA_SIZE)
    ) u_merge (
      .codeword (sram_rdata[gi*WW +: WW]),
      .wdata    (m_wdata[gi]),
      .wmask    (m_wmask[gi]),
      .inj_msk  (m_inj[gi]),
      .rdata    (rdata_o[gi*DATA_SIZE +: DATA_SIZE]),
      .err_cor  (w_cor[gi]),
      .err_unc  (w_unc[gi]),
      .enc_word (sram_wdata[gi*WW +: WW])
    );
  end

  // SRAM port arbitration: RMW merge, then write-back, then a new request.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = req_addr_i;
    sram_wmask = '0;
    if (rmw_active) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = rmw_addr_reg;
      for (int i = 0; i < NDATA; i++) begin
        sram_wmask[i*WW +: WW] = {WW{(|rmw_wmask_reg[i*DATA_SIZE +: DATA_SIZE]) && !w_unc[i]}};
      end
    end else if (wb_active) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = rd_addr_reg;
      sram_wmask = '1;
    end else if (accept) begin
      sram_cs = 1'b1;
      sram_we = req_we_i && !any_partial;
      if (req_we_i && !any_partial) begin
        for (int i = 0; i < NDATA; i++) begin
          sram_wmask[i*WW +: WW] = {WW{word_all1[i]}};
        end
      end
    end
  end

  hpdcache_sram_wmask_1rw #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (WW),
    .DEPTH     (DEPTH),
    .NDATA     (NDATA)
  ) u_sram (
    .clk   (clk),
    .cs    (sram_cs),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .wmask (sram_wmask),
    .rdata (sram_rdata)
  );

  // Request FSM: reads and full writes stay in IDLE, partial writes go through RMW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rvalid_reg    <= 1'b0;
      rd_addr_reg   <= '0;
      rmw_addr_reg  <= '0;
      rmw_wdata_reg <= '0;
      rmw_wmask_reg <= '0;
      rmw_inj_reg   <= '0;
    end else begin
      rvalid_reg <= accept && !req_we_i;
      if (accept && !req_we_i) begin
        rd_addr_reg <= req_addr_i;
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept && req_we_i && any_partial) begin
            state_reg     <= ST_RMW;
            rmw_addr_reg  <= req_addr_i;
            rmw_wdata_reg <= req_wdata_i;
            rmw_wmask_reg <= req_wmask_i;
            rmw_inj_reg   <= err_inj_i ? err_inj_msk_i : '0;
          end
        end
        ST_RMW: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ev_valid = rvalid_reg || rmw_active;
  assign ev_cor   = ev_valid && (|w_cor);
  assign ev_unc   = ev_valid && (|w_unc);
  assign ev_addr  = rmw_active ? rmw_addr_reg : rd_addr_reg;

  // Saturating error counters and last-error address log; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_cnt_reg        <= '0;
      unc_cnt_reg        <= '0;
      err_addr_reg       <= '0;
      err_addr_valid_reg <= 1'b0;
    end else if (cnt_clr_i) begin
      cor_cnt_reg        <= '0;
      unc_cnt_reg        <= '0;
      err_addr_reg       <= '0;
      err_addr_valid_reg <= 1'b0;
    end else begin
      if (ev_cor && (cor_cnt_reg != '1)) begin
        cor_cnt_reg <= cor_cnt_reg + 1'b1;
      end
      if (ev_unc && (unc_cnt_reg != '1)) begin
        unc_cnt_reg <= unc_cnt_reg + 1'b1;
      end
      if (ev_cor || ev_unc) begin
        err_addr_reg       <= ev_addr;
        err_addr_valid_reg <= 1'b1;
      end
    end
  end

  assign rvalid_o         = rvalid_reg;
  assign err_cor_o        = rvalid_reg ? w_cor : '0;
  assign err_unc_o        = rvalid_reg ? w_unc : '0;
  assign cor_cnt_o        = cor_cnt_reg;
  assign unc_cnt_o        = unc_cnt_reg;
  assign err_addr_o       = err_addr_reg;
  assign err_addr_valid_o = err_addr_valid_reg;

endmodule

// File: tb/tb_hpdcache_sram_wmask_ecc_rmw_1rw.sv
// Directed bench: table of write-then-read vectors plus hand sequences for
// RMW timing, write-back, uncorrectable merge, saturation, clear and reset.
module tb_hpdcache_sram_wmask_ecc_rmw_1rw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [63:0] req_wmask = '0;
  logic        rvalid;
  logic [63:0] rdata;
  logic [1:0]  err_cor;
  logic [1:0]  err_unc;
  logic        err_inj = 1'b0;
  logic [63:0] err_inj_msk = '0;
  logic        cnt_clr = 1'b0;
  logic [7:0]  cor_cnt;
  logic [7:0]  unc_cnt;
  logic [5:0]  err_addr;
  logic        err_addr_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hpdcache_sram_wmask_ecc_rmw_1rw dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .req_wmask_i      (req_wmask),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
    .err_cor_o        (err_cor),
    .err_unc_o        (err_unc),
    .err_inj_i        (err_inj),
    .err_inj_msk_i    (err_inj_msk),
    .cnt_clr_i        (cnt_clr),
    .cor_cnt_o        (cor_cnt),
    .unc_cnt_o        (unc_cnt),
    .err_addr_o       (err_addr),
    .err_addr_valid_o (err_addr_valid)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [63:0] inj;
    logic [63:0] exp;
    logic [63:0] dcare;
    logic [1:0]  ecor;
    logic [1:0]  eunc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Present one request and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic issue(input logic we, input logic [5:0] addr, input logic [63:0] wd,
                       input logic [63:0] wm, input logic [63:0] im);
    int waited;
    @(negedge clk);
    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wd;
    req_wmask   = wm;
    err_inj     = (im != '0);
    err_inj_msk = im;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready stayed %b, required 1", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    err_inj     = 1'b0;
    err_inj_msk = '0;
  endtask

  // Read a row and capture everything visible in the response cycle.
  task automatic do_read(input logic [5:0] addr, output logic v, output logic [63:0] d,
                         output logic [1:0] c, output logic [1:0] u, output logic rdy);
    issue(1'b0, addr, '0, '0, '0);
    v   = rvalid;
    d   = rdata;
    c   = err_cor;
    u   = err_unc;
    rdy = req_ready;
  endtask

  logic        v;
  logic [63:0] d;
  logic [1:0]  c;
  logic [1:0]  u;
  logic        rdy;

  initial begin
    vecs[0] = '{6'd5,  64'h12345678_DEADBEEF, '1, '0, 64'h12345678_DEADBEEF, '1, 2'b00, 2'b00};
    vecs[1] = '{6'd5,  64'h00000000_00000011, 64'h00000000_000000FF, '0, 64'h12345678_DEADBE11, '1, 2'b00, 2'b00};
    vecs[2] = '{6'd3,  64'h11111111_22222222, '1, '0, 64'h11111111_22222222, '1, 2'b00, 2'b00};
    vecs[3] = '{6'd3,  64'hCAFEF00D_99999999, 64'hFFFFFFFF_00000000, '0, 64'hCAFEF00D_22222222, '1, 2'b00, 2'b00};
    vecs[4] = '{6'd3,  64'h12340000_0000ABCD, 64'hFFFF0000_0000FFFF, '0, 64'h1234F00D_2222ABCD, '1, 2'b00, 2'b00};
    vecs[5] = '{6'd3,  64'hFFFFFFFF_00000000, 64'h0000000F_80000001, '0, 64'h1234F00F_2222ABCC, '1, 2'b00, 2'b00};
    vecs[6] = '{6'd12, 64'h55AA55AA_01234567, '1, 64'h00000000_00000001, 64'h55AA55AA_01234567, '1, 2'b01, 2'b00};
    vecs[7] = '{6'd13, 64'hFFFFFFFF_00000000, '1, 64'h00000003_00000000, 64'h00000000_00000000, 64'h00000000_FFFFFFFF, 2'b00, 2'b10};
    vecs[8] = '{6'd3,  64'h00000000_000000A0, 64'h00000000_000000F0, 64'h00000000_80000000, 64'h1234F00F_2222ABAC, '1, 2'b01, 2'b00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
    chk("reset_cor_cnt", {56'd0, cor_cnt}, 64'd0);
    chk("reset_unc_cnt", {56'd0, unc_cnt}, 64'd0);
    chk("reset_err_addr_valid", {63'd0, err_addr_valid}, 64'd0);
    chk("reset_err_cor", {62'd0, err_cor}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: write then read each vector
    for (int i = 0; i < 9; i++) begin
      issue(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].inj);
      do_read(vecs[i].addr, v, d, c, u, rdy);
      chk($sformatf("vec%0d_rvalid", i), {63'd0, v}, 64'd1);
      chk($sformatf("vec%0d_rdata", i), d & vecs[i].dcare, vecs[i].exp & vecs[i].dcare);
      chk($sformatf("vec%0d_err_cor", i), {62'd0, c}, {62'd0, vecs[i].ecor});
      chk($sformatf("vec%0d_err_unc", i), {62'd0, u}, {62'd0, vecs[i].eunc});
    end

    // Clear counters and log
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_cor_cnt", {56'd0, cor_cnt}, 64'd0);
    chk("clr_unc_cnt", {56'd0, unc_cnt}, 64'd0);
    chk("clr_err_addr_valid", {63'd0, err_addr_valid}, 64'd0);

    // Partial write: ready low for exactly one cycle, no rvalid
    issue(1'b1, 6'd5, 64'h0, 64'hF0000000_00000000, '0);
    chk("rmw_ready_low", {63'd0, req_ready}, 64'd0);
    chk("rmw_no_rvalid", {63'd0, rvalid}, 64'd0);
    @(posedge clk);
    #1;
    chk("rmw_ready_back", {63'd0, req_ready}, 64'd1);
    do_read(6'd5, v, d, c, u, rdy);
    chk("rmw_row5_data", d, 64'h02345678_DEADBE11);
    chk("rmw_row5_errs", {60'd0, c, u}, 64'd0);

    // Correctable error on row 7 word1 with write-back
    issue(1'b1, 6'd7, 64'h0F0F0F0F_76543210, '1, 64'h00000008_00000000);
    do_read(6'd7, v, d, c, u, rdy);
    chk("row7_data", d, 64'h0F0F0F0F_76543210);
    chk("row7_err_cor", {62'd0, c}, 64'd2);
    chk("row7_wb_ready_low", {63'd0, rdy}, 64'd0);
    @(posedge clk);
    #1;
    chk("row7_cor_cnt", {56'd0, cor_cnt}, 64'd1);
    chk("row7_err_addr", {57'd0, err_addr_valid, err_addr}, {57'd0, 1'b1, 6'd7});
    do_read(6'd7, v, d, c, u, rdy);
    chk("row7_after_wb_errs", {60'd0, c, u}, 64'd0);
    chk("row7_after_wb_data", d, 64'h0F0F0F0F_76543210);

    // Uncorrectable word0 on row 9 survives a partial write; word1 merges
    issue(1'b1, 6'd9, 64'h13579BDF_2468ACE0, '1, 64'h00000000_00000030);
    issue(1'b1, 6'd9, 64'hBEEF0000_00000011, 64'hFFFF0000_000000FF, '0);
    @(posedge clk);
    #1;
    chk("row9_unc_cnt", {56'd0, unc_cnt}, 64'd1);
    chk("row9_cor_cnt", {56'd0, cor_cnt}, 64'd1);
    chk("row9_err_addr", {58'd0, err_addr}, 64'd9);
    do_read(6'd9, v, d, c, u, rdy);
    chk("row9_data", d, 64'hBEEF9BDF_2468ACD0);
    chk("row9_err_unc", {62'd0, u}, 64'd1);
    chk("row9_err_cor", {62'd0, c}, 64'd0);
    chk("row9_no_wb", {63'd0, rdy}, 64'd1);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      issue(1'b1, 6'd20, {i[31:0], ~i[31:0]}, '1, 64'h00000000_00000020);
      do_read(6'd20, v, d, c, u, rdy);
    end
    @(posedge clk);
    #1;
    chk("sat_cor_cnt", {56'd0, cor_cnt}, 64'd255);
    chk("sat_unc_cnt", {56'd0, unc_cnt}, 64'd2);

    // Clear on an event cycle wins over the increment
    issue(1'b1, 6'd20, 64'h0, '1, 64'h00000000_00000020);
    do_read(6'd20, v, d, c, u, rdy);
    chk("clr_event_err_cor", {62'd0, c}, 64'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_event_cor_cnt", {56'd0, cor_cnt}, 64'd0);
    chk("clr_event_err_addr_valid", {63'd0, err_addr_valid}, 64'd0);

    // Reset during the RMW merge cycle drops the write
    issue(1'b1, 6'd5, 64'h00000000_00000077, 64'h00000000_000000FF, '0);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rmw_rvalid", {63'd0, rvalid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(6'd5, v, d, c, u, rdy);
    chk("rst_rmw_row5_data", d, 64'h02345678_DEADBE11);
    chk("rst_rmw_row5_errs", {60'd0, c, u}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
